// File: rtl/elevator_pkg.sv
// Shared types for the elevator car: the signed floor type, the legal floor range,
// and the car state encoding. The zone decoder and the bench use these too.
package elevator_pkg;

    typedef logic signed [3:0] floor_t;

    localparam floor_t FLOOR_MIN = -4;
    localparam floor_t FLOOR_MAX = 7;

    // Wide enough for any practical travel/door time.
    localparam int TIMER_W = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_t;

    function automatic logic floor_legal(input floor_t f);
        return (f >= FLOOR_MIN) && (f <= FLOOR_MAX);
    endfunction

endpackage

// File: rtl/elevator_timer.sv
// Phase timer shared by travel and door phases: counts up while enabled and
// wraps to zero on the cycle it sits at the terminal count.
module elevator_timer
    import elevator_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic [TIMER_W-1:0] tc_val,
    output logic               at_tc
);

    logic [TIMER_W-1:0] count_q, count_d;

    assign at_tc = (count_q == tc_val);

    always_comb begin
        count_d = count_q;
        if (clr || (en && at_tc)) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/elevator_car.sv
// Car motion FSM: accepts one target floor in IDLE, steps one floor per
// FLOOR_CYCLES clocks toward it, then holds the door for DOOR_CYCLES clocks.
module elevator_car
    import elevator_pkg::*;
#(
    parameter int FLOOR_CYCLES = 4,
    parameter int DOOR_CYCLES  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [3:0] req_floor,
    output logic       req_ready,
    output logic       req_error,
    output logic [3:0] current_floor,
    output logic       moving_up,
    output logic       moving_down,
    output logic       door_open,
    output logic       arrived
);

    localparam logic [TIMER_W-1:0] FLOOR_TC = TIMER_W'(FLOOR_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_TC  = TIMER_W'(DOOR_CYCLES - 1);

    state_t state_q, state_d;
    floor_t floor_q, floor_d;
    floor_t target_q, target_d;
    logic   error_q, error_d;
    logic   arrived_q, arrived_d;
    floor_t req_f;
    floor_t floor_up, floor_dn;
    logic   tmr_tc;

    assign req_f    = $signed(req_floor);
    assign floor_up = floor_q + floor_t'(1);
    assign floor_dn = floor_q - floor_t'(1);

    // Timer idles at zero in IDLE, so every phase starts counting from 0.
    elevator_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q == IDLE),
        .en     (state_q != IDLE),
        .tc_val ((state_q == DOOR_OPEN) ? DOOR_TC : FLOOR_TC),
        .at_tc  (tmr_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            floor_q   <= '0;
            target_q  <= '0;
            error_q   <= 1'b0;
            arrived_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            target_q  <= target_d;
            error_q   <= error_d;
            arrived_q <= arrived_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        target_d = target_q;
        error_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (floor_legal(req_f)) begin
                        target_d = req_f;
                        if (req_f == floor_q)     state_d = DOOR_OPEN;
                        else if (req_f > floor_q) state_d = MOVE_UP;
                        else                      state_d = MOVE_DOWN;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            MOVE_UP: begin
                if (tmr_tc) begin
                    floor_d = floor_up;
                    if (floor_up == target_q) state_d = DOOR_OPEN;
                end
            end
            MOVE_DOWN: begin
                if (tmr_tc) begin
                    floor_d = floor_dn;
                    if (floor_dn == target_q) state_d = DOOR_OPEN;
                end
            end
            DOOR_OPEN: begin
                if (tmr_tc) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        arrived_d = (state_d == DOOR_OPEN) && (state_q != DOOR_OPEN);
    end

    always_comb begin
        req_ready     = (state_q == IDLE);
        moving_up     = (state_q == MOVE_UP);
        moving_down   = (state_q == MOVE_DOWN);
        door_open     = (state_q == DOOR_OPEN);
        req_error     = error_q;
        arrived       = arrived_q;
        current_floor = floor_q;
    end

endmodule

// File: doc/elevator_car.md
# elevator_car

Sequential car-motion block that produces the 4-bit two's-complement floor number consumed by the zone decoder (P/S/G/Error classifier). Accepts one target-floor request at a time over a valid/ready handshake, moves the car one floor per FLOOR_CYCLES clocks, holds the doors open for DOOR_CYCLES clocks on arrival, then returns to idle. Rejects targets outside the legal range -4..7.

## Interface
- FLOOR_CYCLES, 4: clocks spent travelling between adjacent floors; legal values are 1 or more.
- DOOR_CYCLES, 3: clocks the door stays open after arrival; legal values are 1 or more.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_floor  in  4  target floor, two's complement.
- req_ready  out  1  high only in IDLE.
- req_error  out  1  one-cycle pulse: the accepted target was illegal.
- current_floor  out  4  car floor, two's complement; feeds the zone decoder.
- moving_up  out  1  state is MOVE_UP.
- moving_down  out  1  state is MOVE_DOWN.
- door_open  out  1  state is DOOR_OPEN.
- arrived  out  1  one-cycle pulse on the first DOOR_OPEN cycle.

## Operation
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN. Reset state is IDLE.
- Reset values:
  - current_floor = 4'b0000 (floor 0).
  - Timer = 0, target register = 0.
  - req_error, arrived, moving_up, moving_down and door_open are all 0.
  - req_ready = 1, decoded from IDLE.
- Handshake: a request is accepted on the edge where req_valid && req_ready. req_valid outside IDLE is ignored and is not queued.
- Legality: a target is legal when it lies in -4..7, i.e. signed value ≥ -4. Codes 4'b1000..4'b1011 (-8..-5) are illegal.
- Illegal accepted target:
  - State stays IDLE.
  - req_error = 1 for exactly the next cycle.
  - current_floor is unchanged.
- Legal target (all comparisons are signed):
  - target == current_floor → DOOR_OPEN, with arrived pulsed.
  - target > current_floor → MOVE_UP.
  - target < current_floor → MOVE_DOWN.
  - The target is latched into an internal register at acceptance.
- MOVE_x:
  - The timer counts 0..FLOOR_CYCLES-1.
  - On the edge where timer == FLOOR_CYCLES-1, current_floor steps ±1 and the timer clears.
  - If the new floor equals the target, the state goes to DOOR_OPEN on that same edge.
- DOOR_OPEN:
  - The timer counts 0..DOOR_CYCLES-1, then the state returns to IDLE and the timer clears.
  - arrived is high only during the first DOOR_OPEN cycle.
- Arithmetic:
  - current_floor is a signed 4-bit value.
  - Wrap-around is impossible by construction, because legality is checked and the car moves monotonically toward the target.
  - current_floor never leaves -4..7.
- Reset mid-operation: async assertion forces IDLE at floor 0 immediately, regardless of state; any in-flight request is dropped.

## Timing
- All outputs are registered or decoded directly from the state register; there is no combinational path from req_* to outputs other than through state.
- Travel latency: with acceptance at edge E and distance d = |target − floor|:
  - current_floor reaches the target at edge E + d·FLOOR_CYCLES.
  - arrived is high during the following cycle.
- Same-floor request: DOOR_OPEN and arrived start at the cycle after acceptance.
- Door time: DOOR_OPEN lasts exactly DOOR_CYCLES cycles. req_ready rises in the cycle after that.
- Minimum request-to-request spacing: d·FLOOR_CYCLES + DOOR_CYCLES + 1 cycles.
- req_error timing: rises in the cycle after acceptance. A new request is allowed in that same cycle, since req_ready stays 1.
- current_floor changes only in MOVE states, at most once per FLOOR_CYCLES cycles.

## Structure
- Package elevator_pkg holds:
  - The floor typedef (logic signed [3:0]).
  - FLOOR_MIN = -4 and FLOOR_MAX = 7.
  - The state enum {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN}.
  - These are shared with the zone decoder and the testbench.
- One sub-module, elevator_timer:
  - A parameter-free width counter with clear and enable inputs and a terminal-count compare input.
  - Instantiated once and shared between the MOVE and DOOR phases.
- The top module contains the FSM, the target register and the floor register.

## Test plan
- Reset, then request 3 with FLOOR_CYCLES=4 and DOOR_CYCLES=3:
  - current_floor steps 1, 2, 3 at 4-cycle intervals.
  - moving_up is high for 12 cycles.
  - arrived pulses once; door_open is high for 3 cycles; req_ready then returns to 1.
- From floor 3, request -4 (4'b1100):
  - moving_down is held for 28 cycles; the floor passes 2, 1, 0, -1, -2, -3, -4.
  - current_floor is never less than -4.
- Request -6 (4'b1010) in IDLE:
  - req_error pulses for 1 cycle.
  - State stays IDLE, current_floor is unchanged and there is no arrived pulse.
- Request equal to current_floor: door_open and arrived start the next cycle; there is no movement.
- req_valid held high during MOVE_UP toward 7 with req_floor = -2:
  - The second request is ignored until IDLE.
  - It is then accepted and executed.
- Assert rst asynchronously mid-MOVE_DOWN (floor -2):
  - Outputs immediately show floor 0, IDLE and req_ready = 1.
  - After rst release, a fresh request to 2 completes normally.
